fetch_align_stage: RTL and testbench
====================================

# fetch_align_stage

Second fetch stage: consumes 256-bit (32-byte) instruction blocks from the L1 instruction-cache fetch stage and drives that stage's block address. Extracts variable-length instructions at a byte offset and stitches instructions that straddle two blocks. Presents one left-aligned 32-bit instruction per handshake to decode. Handles branch redirects by flushing and re-steering the fetch address.

## Interface
- FETCH_LAT, 3: minimum cycles from a blockAddr_o change to a valid block for that address.
- clock_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-low reset.
- blockAddr_o  out  11  block address driven to the i-cache stage.
- block_i  in  256  fetched block; byte k = block_i[255-8k -: 8].
- enable_i  in  1  block_i valid this cycle.
- redirect_i  in  1  branch redirect, 1-cycle pulse.
- redirectAddr_i  in  16  redirect target {block[15:5], byte[4:0]}.
- instr_o  out  32  instruction, left-aligned; unused low bytes zero.
- instrAddr_o  out  16  {block, byte} address of instr_o.
- valid_o  out  1  instr_o valid.
- ready_i  in  1  decode accepts instr_o when valid_o && ready_i.
- misalign_o  out  1  1-cycle pulse: straddling instruction dropped (macro off only).

## Operation
- Reset (reset_i=0 at posedge): blockAddr_o=0, instr_o=0, instrAddr_o=0, valid_o=0, misalign_o=0, offset=0, wait count=0, partial cleared, state WAIT.
- Length: first byte bit 7 = format. 1 (reg-imm, 30 bits + 2 pad) = 4 bytes; 0 (reg-reg, 19 bits + 5 pad) = 3 bytes.
- States: WAIT, PARSE, STITCH.
- WAIT: blockAddr_o held stable; count saturates at FETCH_LAT. When count==FETCH_LAT and enable_i=1, capture block_i into block register → PARSE, or → STITCH if a partial is pending. enable_i while count<FETCH_LAT is ignored (stale block).
- PARSE: output slot free when !valid_o || ready_i; otherwise hold all state.
  - offset+len<=32: load instr_o, instrAddr_o={blockAddr_o,offset}, valid_o=1, offset+=len.
  - Result offset==32: blockAddr_o+=1 (2047 wraps to 0), offset=0, count=0 → WAIT, in the same cycle the instruction is loaded.
  - offset+len>32: straddle, see Configuration.
- STITCH: instr = partial bytes (32-offset of them, at least 1) followed by the first len-(32-offset) bytes of the new block. instrAddr_o = previous block and offset. Emit when slot free, then offset = len-(32-offset) → PARSE.
- No instruction issued → valid_o drops to 0 after a handshake.
- Redirect has priority over all other activity. Next cycle: valid_o=0, partial dropped, blockAddr_o=redirectAddr_i[15:5], offset=redirectAddr_i[4:0], count=0 → WAIT.
- Redirect coinciding with a handshake: that handshake completes (consumer keeps it), then the flush applies.
- Redirect coinciding with enable_i: the block is discarded.

## Timing
- Block request to acceptance: at least FETCH_LAT cycles, plus one per enable_i=0 bubble (i-cache write cycles).
- Acceptance to first valid_o: 1 cycle.
- Within a block: one instruction per cycle while ready_i=1.
- Block boundary: at least FETCH_LAT+1 cycles with no issue.
- Backpressure: instr_o, instrAddr_o and valid_o stay stable while valid_o && !ready_i.
- misalign_o is 1 for exactly one cycle.

## Configuration
- FETCH_ALIGN_STITCH_EN defined:
  - Straddle saves bytes offset..31 as partial, increments blockAddr_o, sets count=0, → WAIT, then STITCH.
  - misalign_o is tied 0.
- FETCH_ALIGN_STITCH_EN undefined:
  - No STITCH state and no partial register.
  - Straddle pulses misalign_o, emits nothing, sets blockAddr_o+=1 and offset=0 → WAIT.

## Test plan
- Block0 bytes 0-3 = 0x85040014, bytes 4-6 = 0x010440, ready_i=1 → instr_o 0x85040014 @0x0000, then 0x01044000 @0x0004 on consecutive cycles.
- ready_i=0 for 5 cycles with first instr valid → instr_o/valid_o unchanged; second instr appears the cycle after ready_i rises.
- Macro on: 4-byte 0x85040014 at block0 byte 30 → blockAddr_o becomes 1; after block1 arrives, instr_o=0x85040014, instrAddr_o=0x001E, next offset 2. Macro off: misalign_o pulses, no instr issued.
- Block-address wrap: blockAddr_o=2047, final instr ends at byte 32 → blockAddr_o=0, offset 0.
- redirect_i with redirectAddr_i=0x0123 while valid_o=1, ready_i=0 → valid_o=0 next cycle, blockAddr_o=9, first issued instrAddr_o=0x0123. An enable_i arriving within FETCH_LAT cycles is ignored.
- reset_i=0 mid-STITCH → all outputs at reset values next cycle. After release, fetch restarts at block 0, offset 0.

Source files
------------

// File: rtl/fetch_align_stage.sv
// fetch_align_stage: extracts left-aligned 3/4-byte instructions from 32-byte i-cache blocks.
// `define FETCH_ALIGN_STITCH_EN to stitch block-straddling instructions; otherwise they drop with misalign_o.
module fetch_align_stage #(
    parameter int FETCH_LAT = 3
) (
    input  logic         clock_i,
    input  logic         reset_i,
    output logic [10:0]  blockAddr_o,
    input  logic [255:0] block_i,
    input  logic         enable_i,
    input  logic         redirect_i,
    input  logic [15:0]  redirectAddr_i,
    output logic [31:0]  instr_o,
    output logic [15:0]  instrAddr_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         misalign_o
);
    localparam int CW = $clog2(FETCH_LAT + 1);
`ifdef FETCH_ALIGN_STITCH_EN
    typedef enum logic [1:0] {WAIT, PARSE, STITCH} state_t;
`else
    typedef enum logic [0:0] {WAIT, PARSE} state_t;
`endif
    state_t         state_q, state_d;
    logic [10:0]    blk_q, blk_d;
    logic [4:0]     off_q, off_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [255:0]   block_q, block_d;
    logic [31:0]    instr_q, instr_d;
    logic [15:0]    iaddr_q, iaddr_d;
    logic           valid_q, valid_d;
    logic [31:0]    win;
    logic [2:0]     len;
    logic [5:0]     fin;
    logic           free;
`ifdef FETCH_ALIGN_STITCH_EN
    logic [23:0]    part_q, part_d;
    logic           part_v_q, part_v_d;
    logic [5:0]     n;
    logic [2:0]     st_len;
    logic [31:0]    st;
`else
    logic           mis_q, mis_d;
`endif

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        block_d = block_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
        valid_d = valid_q && !ready_i;
        free    = !valid_q || ready_i;
        // Bytes beyond the block end read as zero through the 24-bit pad.
        win     = 32'({block_q, 24'b0} >> (9'd248 - {1'b0, off_q, 3'b0}));
        len     = win[31] ? 3'd4 : 3'd3;
        fin     = {1'b0, off_q} + {3'b0, len};
`ifdef FETCH_ALIGN_STITCH_EN
        part_d   = part_q;
        part_v_d = part_v_q;
        n        = 6'd32 - {1'b0, off_q};
        st_len   = part_q[23] ? 3'd4 : 3'd3;
        st       = 32'(({part_q, 32'b0} | ({block_q[255:224], 24'b0} >> {n, 3'b0})) >> 24);
`else
        mis_d    = 1'b0;
`endif
        if (redirect_i) begin
            valid_d = 1'b0;
            blk_d   = redirectAddr_i[15:5];
            off_d   = redirectAddr_i[4:0];
            cnt_d   = '0;
            state_d = WAIT;
`ifdef FETCH_ALIGN_STITCH_EN
            part_v_d = 1'b0;
`endif
        end else if (state_q == WAIT) begin
            if (cnt_q != CW'(FETCH_LAT)) begin
                cnt_d = cnt_q + CW'(1);
            end else if (enable_i) begin
                block_d = block_i;
`ifdef FETCH_ALIGN_STITCH_EN
                state_d = part_v_q ? STITCH : PARSE;
`else
                state_d = PARSE;
`endif
            end
        end else if (state_q == PARSE) begin
            if (free && fin <= 6'd32) begin
                instr_d = win[31] ? win : {win[31:8], 8'h00};
                iaddr_d = {blk_q, off_q};
                valid_d = 1'b1;
                off_d   = fin[4:0];
                if (fin == 6'd32) begin
                    blk_d   = blk_q + 11'd1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end else if (free) begin
                blk_d   = blk_q + 11'd1;
                cnt_d   = '0;
                state_d = WAIT;
`ifdef FETCH_ALIGN_STITCH_EN
                part_d   = win[31:8];
                part_v_d = 1'b1;
`else
                off_d    = '0;
                mis_d    = 1'b1;
`endif
            end
        end
`ifdef FETCH_ALIGN_STITCH_EN
        else if (free) begin
            instr_d  = st_len[2] ? st : {st[31:8], 8'h00};
            iaddr_d  = {blk_q - 11'd1, off_q};
            valid_d  = 1'b1;
            off_d    = 5'({3'b0, st_len} - n);
            part_v_d = 1'b0;
            state_d  = PARSE;
        end
`endif
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= WAIT;
            blk_q   <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            block_q <= '0;
            instr_q <= '0;
            iaddr_q <= '0;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_STITCH_EN
            part_q   <= '0;
            part_v_q <= 1'b0;
`else
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
            valid_q <= valid_d;
`ifdef FETCH_ALIGN_STITCH_EN
            part_q   <= part_d;
            part_v_q <= part_v_d;
`else
            mis_q    <= mis_d;
`endif
        end
    end

    assign blockAddr_o = blk_q;
    assign instr_o     = instr_q;
    assign instrAddr_o = iaddr_q;
    assign valid_o     = valid_q;
`ifdef FETCH_ALIGN_STITCH_EN
    assign misalign_o  = 1'b0;
`else
    assign misalign_o  = mis_q;
`endif
endmodule

// File: tb/tb_fetch_align_stage.sv
// tb_fetch_align_stage: table-driven vectors plus directed straddle, redirect, wrap and reset sequences.
module tb_fetch_align_stage;
    localparam logic [255:0] B0 = {8'h85, 8'h04, 8'h00, 8'h14, 8'h01, 8'h04, 8'h40,
                                   8'h80, 8'h11, 8'h22, 8'h33, 168'h0};
    localparam logic [255:0] B4 = {240'h0, 8'h85, 8'h04};
    localparam logic [255:0] B5 = {8'h00, 8'h14, 8'h80, 8'hAA, 8'hBB, 8'hCC, 208'h0};
    localparam logic [255:0] B9 = {24'h0, 8'h81, 8'h23, 8'h45, 8'h67, 200'h0};
    localparam logic [255:0] BL = {224'h0, 32'h8ABCDEF0};

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic [10:0]  blockAddr_o;
    logic [255:0] block_i;
    logic         enable_i;
    logic         redirect_i;
    logic [15:0]  redirectAddr_i;
    logic [31:0]  instr_o;
    logic [15:0]  instrAddr_o;
    logic         valid_o;
    logic         ready_i;
    logic         misalign_o;
    logic         bad = 1'b0;
    int           checks = 0;
    int           errors = 0;
    int           mis_cnt = 0;
    int           mis0;

    typedef struct {
        logic        rdy;
        logic        v;
        logic [31:0] ins;
        logic [15:0] ad;
        logic [10:0] blk;
    } vec_t;
    vec_t tbl [24];

    fetch_align_stage dut (
        .clock_i(clock_i), .reset_i(reset_i), .blockAddr_o(blockAddr_o),
        .block_i(block_i), .enable_i(enable_i), .redirect_i(redirect_i),
        .redirectAddr_i(redirectAddr_i), .instr_o(instr_o), .instrAddr_o(instrAddr_o),
        .valid_o(valid_o), .ready_i(ready_i), .misalign_o(misalign_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [255:0] mem(input logic [10:0] a);
        case (a)
            11'd0:    return B0;
            11'd4:    return B4;
            11'd5:    return B5;
            11'd9:    return B9;
            11'd2047: return BL;
            default:  return '0;
        endcase
    endfunction

    always_comb block_i = bad ? '1 : mem(blockAddr_o);

    always @(negedge clock_i) if (reset_i && misalign_o) mis_cnt++;

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [31:0] ins,
                           input logic [15:0] ad, input logic [10:0] blk);
        chk({nm, ".valid"}, 32'(valid_o), 32'(v));
        chk({nm, ".instr"}, instr_o, ins);
        chk({nm, ".addr"}, 32'(instrAddr_o), 32'(ad));
        chk({nm, ".blk"}, 32'(blockAddr_o), 32'(blk));
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!valid_o && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (!valid_o) begin
            errors++;
            $display("FAIL %s timeout valid_o=0 want 1", nm);
        end
    endtask

    task automatic redirect(input logic [15:0] a);
        redirect_i = 1'b1;
        redirectAddr_i = a;
        tick;
        redirect_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, 1'b0, 32'h0, 16'h0, 11'd0};
        tbl[4] = '{1'b0, 1'b1, 32'h85040014, 16'h0000, 11'd0};
        for (int i = 5; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 32'h85040014, 16'h0000, 11'd0};
        tbl[10] = '{1'b1, 1'b1, 32'h01044000, 16'h0004, 11'd0};
        tbl[11] = '{1'b1, 1'b1, 32'h80112233, 16'h0007, 11'd0};
        for (int i = 12; i < 19; i++)
            tbl[i] = '{1'b1, 1'b1, 32'h0, 16'(16'h000B + 3 * (i - 12)), 11'(i == 18)};
        for (int i = 19; i < 23; i++) tbl[i] = '{1'b1, 1'b0, 32'h0, 16'h001D, 11'd1};
        tbl[23] = '{1'b1, 1'b1, 32'h0, 16'h0020, 11'd1};

        reset_i = 1'b0;
        ready_i = 1'b0;
        enable_i = 1'b1;
        redirect_i = 1'b0;
        redirectAddr_i = '0;
        tick;
        tick;
        chk_out("reset", 1'b0, 32'h0, 16'h0, 11'd0);
        chk("reset.misalign", 32'(misalign_o), 32'h0);
        reset_i = 1'b1;

        for (int i = 0; i < 24; i++) begin
            ready_i = tbl[i].rdy;
            tick;
            chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].ins, tbl[i].ad, tbl[i].blk);
        end

        redirect(16'h009E);
        chk("strad.redir_valid", 32'(valid_o), 32'h0);
        chk("strad.redir_blk", 32'(blockAddr_o), 32'd4);
        mis0 = mis_cnt;
        wait_valid("strad.wait");
        chk("strad.blk", 32'(blockAddr_o), 32'd5);
`ifdef FETCH_ALIGN_STITCH_EN
        chk("strad.instr", instr_o, 32'h85040014);
        chk("strad.addr", 32'(instrAddr_o), 32'h009E);
        chk("strad.mis", 32'(mis_cnt - mis0), 32'd0);
        tick;
        chk("strad.next_instr", instr_o, 32'h80AABBCC);
        chk("strad.next_addr", 32'(instrAddr_o), 32'h00A2);
`else
        chk("strad.instr", instr_o, 32'h00148000);
        chk("strad.addr", 32'(instrAddr_o), 32'h00A0);
        chk("strad.mis", 32'(mis_cnt - mis0), 32'd1);
        tick;
        chk("strad.next_instr", instr_o, 32'hAABBCC00);
        chk("strad.next_addr", 32'(instrAddr_o), 32'h00A3);
`endif

        ready_i = 1'b0;
        tick;
        wait_valid("redir.pre");
        redirect(16'h0123);
        chk("redir.valid", 32'(valid_o), 32'h0);
        chk("redir.blk", 32'(blockAddr_o), 32'd9);
        bad = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("redir.stale%0d", i), 32'(valid_o), 32'h0);
        end
        bad = 1'b0;
        tick;
        chk("redir.accept", 32'(valid_o), 32'h0);
        tick;
        chk_out("redir.first", 1'b1, 32'h81234567, 16'h0123, 11'd9);

        redirect(16'hFFFC);
        chk("wrap.blk_pre", 32'(blockAddr_o), 32'd2047);
        wait_valid("wrap.wait");
        chk_out("wrap.last", 1'b1, 32'h8ABCDEF0, 16'hFFFC, 11'd0);
        tick;
        chk("wrap.drop", 32'(valid_o), 32'h0);
        wait_valid("wrap.wait0");
        chk_out("wrap.first", 1'b1, 32'h85040014, 16'h0000, 11'd0);

        redirect(16'h009E);
        for (int i = 0; i < 9; i++) tick;
        reset_i = 1'b0;
        tick;
        chk_out("rst_mid", 1'b0, 32'h0, 16'h0, 11'd0);
        chk("rst_mid.misalign", 32'(misalign_o), 32'h0);
        reset_i = 1'b1;
        wait_valid("rst_mid.wait");
        chk_out("rst_mid.first", 1'b1, 32'h85040014, 16'h0000, 11'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
